// File: rtl/prewish5k_pkg.sv
// rtl/prewish5k_pkg.sv - shared state encodings and defaults for the mask sequencer
package prewish5k_pkg;

  typedef enum logic [1:0] {
    P_WAITDIV = 2'd0,
    P_REQ     = 2'd1,
    P_ACK     = 2'd2
  } poll_state_e;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_SEND = 2'd1,
    L_WAIT = 2'd2
  } load_state_e;

  localparam int DEFAULT_ACK_TIMEOUT = 15;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prewish5k_prio_enc.sv
// rtl/prewish5k_prio_enc.sv - lowest-index-first priority encoder with valid flag
module prewish5k_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/prewish5k_mask_sequencer.sv
// rtl/prewish5k_mask_sequencer.sv - polls a button debouncer and issues one mentor mask load per press edge
module prewish5k_mask_sequencer
  import prewish5k_pkg::*;
#(
  parameter int NCHAN         = 4,
  parameter int DW            = 8,
  parameter int POLL_DIV_BITS = 16,
  parameter int ACK_TIMEOUT   = DEFAULT_ACK_TIMEOUT
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic [DW-1:0]               dip_switch,
  output logic                        DBN_STB_O,
  input  logic [NCHAN-1:0]            DBN_DAT_I,
  input  logic                        DBN_STB_I,
  output logic                        MNT_STB_O,
  output logic [DW-1:0]               MNT_DAT_O,
  output logic [sel_width(NCHAN)-1:0] MNT_SEL_O,
  input  logic                        MNT_ACK_I,
  output logic                        o_err,
  output logic                        o_busy,
  output logic                        o_alive
);

  localparam int SW = sel_width(NCHAN);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  poll_state_e              poll_q, poll_d;
  logic [POLL_DIV_BITS-1:0] div_q, div_d;
  logic [TW-1:0]            ptmo_q, ptmo_d;
  logic [NCHAN-1:0]         btn_q, btn_d;
  logic [NCHAN-1:0]         btn_prev_q, btn_prev_d;
  logic                     base_q, base_d;
  logic                     new_q, new_d;
  logic                     dbn_stb_q, dbn_stb_d;
  logic                     alive_q, alive_d;
  logic                     ptmo_err;

  load_state_e              load_q, load_d;
  logic [TW-1:0]            ltmo_q, ltmo_d;
  logic [SW-1:0]            sel_q, sel_d;
  logic [DW-1:0]            dat_q, dat_d;
  logic                     mnt_stb_q, mnt_stb_d;
  logic                     busy_q, busy_d;
  logic                     ltmo_err;

  logic [NCHAN-1:0]         pending_q, pending_d;
  logic [NCHAN-1:0]         new_edges, pend_all, clr_mask;
  logic                     err_q, err_d;
  logic [SW-1:0]            enc_idx;
  logic                     enc_valid;

  // Edges are formed the cycle after a sample lands, from btn_q against btn_prev_q,
  // and fed straight to the encoder so an idle load FSM still strobes at N+2.
  assign new_edges = new_q ? (btn_q & ~btn_prev_q) : '0;
  assign pend_all  = pending_q | new_edges;

  prewish5k_prio_enc #(
    .N  (NCHAN),
    .IW (SW)
  ) u_prio_enc (
    .req   (pend_all),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    poll_d     = poll_q;
    div_d      = div_q;
    ptmo_d     = ptmo_q;
    btn_d      = btn_q;
    btn_prev_d = btn_prev_q;
    base_d     = base_q;
    alive_d    = alive_q;
    new_d      = 1'b0;
    ptmo_err   = 1'b0;
    case (poll_q)
      P_WAITDIV: begin
        if (div_q == '1) begin
          div_d  = '0;
          poll_d = P_REQ;
        end else begin
          div_d = div_q + POLL_DIV_BITS'(1);
        end
      end
      P_REQ: begin
        poll_d = P_ACK;
        ptmo_d = '0;
      end
      P_ACK: begin
        if (DBN_STB_I) begin
          btn_prev_d = btn_q;
          btn_d      = DBN_DAT_I;
          new_d      = base_q;
          base_d     = 1'b1;
          alive_d    = ~alive_q;
          poll_d     = P_WAITDIV;
        end else if (ptmo_q == TMO_LAST) begin
          ptmo_err = 1'b1;
          poll_d   = P_WAITDIV;
        end else if (ptmo_q != '1) begin
          ptmo_d = ptmo_q + TW'(1);
        end
      end
      default: poll_d = P_WAITDIV;
    endcase
    dbn_stb_d = (poll_d == P_REQ);
  end

  always_comb begin
    load_d    = load_q;
    ltmo_d    = ltmo_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    clr_mask  = '0;
    ltmo_err  = 1'b0;
    mnt_stb_d = 1'b0;
    case (load_q)
      L_IDLE: begin
        if (enc_valid) begin
          sel_d     = enc_idx;
          dat_d     = ~dip_switch;
          load_d    = L_SEND;
          mnt_stb_d = 1'b1;
        end
      end
      L_SEND: begin
        load_d = L_WAIT;
        ltmo_d = '0;
      end
      L_WAIT: begin
        if (MNT_ACK_I) begin
          clr_mask = NCHAN'(1) << sel_q;
          load_d   = L_IDLE;
        end else if (ltmo_q == TMO_LAST) begin
          ltmo_err = 1'b1;
          clr_mask = NCHAN'(1) << sel_q;
          load_d   = L_IDLE;
        end else if (ltmo_q != '1) begin
          ltmo_d = ltmo_q + TW'(1);
        end
      end
      default: load_d = L_IDLE;
    endcase
    busy_d    = (load_d != L_IDLE);
    // A fresh edge on the channel being cleared survives the clear.
    pending_d = (pending_q & ~clr_mask) | new_edges;
    err_d     = err_q | ptmo_err | ltmo_err;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      poll_q     <= P_WAITDIV;
      div_q      <= '0;
      ptmo_q     <= '0;
      btn_q      <= '0;
      btn_prev_q <= '0;
      base_q     <= 1'b0;
      new_q      <= 1'b0;
      dbn_stb_q  <= 1'b0;
      alive_q    <= 1'b0;
      load_q     <= L_IDLE;
      ltmo_q     <= '0;
      sel_q      <= '0;
      dat_q      <= '0;
      mnt_stb_q  <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      poll_q     <= poll_d;
      div_q      <= div_d;
      ptmo_q     <= ptmo_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
      base_q     <= base_d;
      new_q      <= new_d;
      dbn_stb_q  <= dbn_stb_d;
      alive_q    <= alive_d;
      load_q     <= load_d;
      ltmo_q     <= ltmo_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
      mnt_stb_q  <= mnt_stb_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
    end
  end

  assign DBN_STB_O = dbn_stb_q;
  assign MNT_STB_O = mnt_stb_q;
  assign MNT_DAT_O = dat_q;
  assign MNT_SEL_O = sel_q;
  assign o_err     = err_q;
  assign o_busy    = busy_q;
  assign o_alive   = alive_q;

endmodule

// File: tb/tb_prewish5k_mask_sequencer.sv
// tb/tb_prewish5k_mask_sequencer.sv - scoreboard bench for the mask sequencer
module tb_prewish5k_mask_sequencer;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] dat;
  } load_t;

  logic       clk;
  logic       RST_I;
  logic [7:0] dip_switch;
  logic       DBN_STB_O;
  logic [3:0] DBN_DAT_I;
  logic       DBN_STB_I;
  logic       MNT_STB_O;
  logic [7:0] MNT_DAT_O;
  logic [1:0] MNT_SEL_O;
  logic       MNT_ACK_I;
  logic       o_err;
  logic       o_busy;
  logic       o_alive;

  prewish5k_mask_sequencer #(
    .NCHAN         (4),
    .DW            (8),
    .POLL_DIV_BITS (2),
    .ACK_TIMEOUT   (15)
  ) dut (
    .CLK_I      (clk),
    .RST_I      (RST_I),
    .dip_switch (dip_switch),
    .DBN_STB_O  (DBN_STB_O),
    .DBN_DAT_I  (DBN_DAT_I),
    .DBN_STB_I  (DBN_STB_I),
    .MNT_STB_O  (MNT_STB_O),
    .MNT_DAT_O  (MNT_DAT_O),
    .MNT_SEL_O  (MNT_SEL_O),
    .MNT_ACK_I  (MNT_ACK_I),
    .o_err      (o_err),
    .o_busy     (o_busy),
    .o_alive    (o_alive)
  );

  int    n_checks = 0;
  int    n_fails  = 0;
  int    stb_seen = 0;
  int    dbn_acks = 0;
  int    acks_base = 0;
  load_t exp_q[$];
  logic [3:0] dbn_q[$];
  logic [3:0] dbn_default;
  logic  dbn_en;
  logic  mnt_en;
  int    mnt_delay;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // which: 0 = MNT_STB_O, 1 = DBN_STB_O
  task automatic wait_stb(input string name, input int which, input int max_cyc);
    int k = 0;
    while (((which == 0) ? MNT_STB_O : DBN_STB_O) == 1'b0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(name, (which == 0) ? MNT_STB_O : DBN_STB_O, 1);
  endtask

  task automatic do_reset();
    RST_I = 1'b1;
    dbn_q.delete();
    repeat (3) @(negedge clk);
    check("reset_outputs", {DBN_STB_O, MNT_STB_O, MNT_DAT_O, MNT_SEL_O, o_err, o_busy, o_alive}, 0);
    acks_base = dbn_acks;
    RST_I = 1'b0;
  endtask

  task automatic end_checks(input string name, input int stb0, input int exp_stb);
    dbn_en = 1'b0;
    repeat (5) @(negedge clk);
    check({name, "_stb_count"}, stb_seen - stb0, exp_stb);
    check({name, "_loads_left"}, exp_q.size(), 0);
    check({name, "_alive"}, o_alive, (dbn_acks - acks_base) % 2);
  endtask

  // Debouncer model: answers each poll one cycle into P_ACK.
  initial begin
    logic [3:0] cur;
    DBN_STB_I = 1'b0;
    DBN_DAT_I = '0;
    forever begin
      @(negedge clk);
      if (DBN_STB_O && dbn_en && !RST_I) begin
        @(negedge clk);
        cur = (dbn_q.size() > 0) ? dbn_q.pop_front() : dbn_default;
        DBN_DAT_I = cur;
        DBN_STB_I = 1'b1;
        @(negedge clk);
        dbn_acks++;
        DBN_STB_I = 1'b0;
      end
    end
  end

  // Mentor model: acknowledges mnt_delay cycles after the load strobe.
  initial begin
    MNT_ACK_I = 1'b0;
    forever begin
      @(negedge clk);
      if (MNT_STB_O && mnt_en && !RST_I) begin
        repeat (mnt_delay) @(negedge clk);
        MNT_ACK_I = 1'b1;
        @(negedge clk);
        MNT_ACK_I = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!RST_I && MNT_STB_O) begin
      load_t e;
      stb_seen++;
      check("load_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("load_sel", MNT_SEL_O, e.sel);
        check("load_dat", MNT_DAT_O, e.dat);
        check("load_busy", o_busy, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int stb0;
    RST_I       = 1'b1;
    dip_switch  = 8'hF0;
    dbn_en      = 1'b1;
    mnt_en      = 1'b1;
    mnt_delay   = 2;
    dbn_default = 4'b0000;

    // Press on ch2 after a clear baseline.
    do_reset();
    stb0 = stb_seen;
    dbn_q.push_back(4'b0000);
    dbn_default = 4'b0100;
    exp_q.push_back('{sel: 2'd2, dat: 8'h0F});
    wait_stb("A_stb", 0, 80);
    repeat (30) @(negedge clk);
    check("A_err", o_err, 0);
    check("A_busy", o_busy, 0);
    end_checks("A", stb0, 1);

    // Baseline of all-pressed produces no load.
    dbn_en = 1'b1;
    dbn_default = 4'b1111;
    do_reset();
    stb0 = stb_seen;
    repeat (60) @(negedge clk);
    end_checks("B", stb0, 0);

    // Two edges in one poll are served lowest index first.
    dbn_en = 1'b1;
    dip_switch = 8'h5A;
    mnt_delay = 3;
    dbn_default = 4'b1010;
    do_reset();
    stb0 = stb_seen;
    dbn_q.push_back(4'b0000);
    exp_q.push_back('{sel: 2'd1, dat: 8'hA5});
    exp_q.push_back('{sel: 2'd3, dat: 8'hA5});
    repeat (80) @(negedge clk);
    check("C_err", o_err, 0);
    end_checks("C", stb0, 2);

    // Mentor never acknowledges.
    dbn_en = 1'b1;
    mnt_en = 1'b0;
    dip_switch = 8'h00;
    dbn_default = 4'b0001;
    do_reset();
    stb0 = stb_seen;
    dbn_q.push_back(4'b0000);
    exp_q.push_back('{sel: 2'd0, dat: 8'hFF});
    wait_stb("D_stb", 0, 80);
    repeat (15) @(negedge clk);
    check("D_err_before", o_err, 0);
    @(negedge clk);
    check("D_err_at15", o_err, 1);
    check("D_busy_after", o_busy, 0);
    repeat (40) @(negedge clk);
    check("D_err_sticky", o_err, 1);
    end_checks("D", stb0, 1);

    // Debouncer never acknowledges.
    dbn_en = 1'b0;
    dbn_default = 4'b0000;
    do_reset();
    stb0 = stb_seen;
    wait_stb("E_dbn_stb", 1, 20);
    @(negedge clk);
    check("E_dbn_pulse", DBN_STB_O, 0);
    repeat (14) @(negedge clk);
    check("E_err_before", o_err, 0);
    @(negedge clk);
    check("E_err_at15", o_err, 1);
    repeat (3) @(negedge clk);
    check("E_no_early_poll", DBN_STB_O, 0);
    @(negedge clk);
    check("E_repoll", DBN_STB_O, 1);
    check("E_stb_count", stb_seen - stb0, 0);

    // Reset while waiting for the mentor.
    dbn_en = 1'b1;
    mnt_en = 1'b0;
    dip_switch = 8'h3C;
    dbn_default = 4'b0100;
    do_reset();
    dbn_q.push_back(4'b0000);
    exp_q.push_back('{sel: 2'd2, dat: 8'hC3});
    wait_stb("F_stb", 0, 80);
    repeat (4) @(negedge clk);
    check("F_busy_wait", o_busy, 1);
    RST_I = 1'b1;
    #1;
    check("F_async_reset", {DBN_STB_O, MNT_STB_O, MNT_DAT_O, MNT_SEL_O, o_err, o_busy, o_alive}, 0);
    check("F_loads_left", exp_q.size(), 0);
    do_reset();
    stb0 = stb_seen;
    repeat (60) @(negedge clk);
    check("F_err", o_err, 0);
    end_checks("F", stb0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
